// File: rtl/lfsr_symbol_gen.sv
// Pseudo-random symbol source: Fibonacci LFSR delivering SYM_BITS-bit symbols over valid/ready.
// Optional snapshot/rewind replay support is built when LFSR_REPLAY_EN is defined.
module lfsr_symbol_gen #(
   parameter int          WIDTH    = 64,
   parameter logic [63:0] TAPS     = 64'hD800_0000_0000_0000,
   parameter logic [63:0] SEED     = 64'h3AFE_6029_F15A_5298,
   parameter int          SYM_BITS = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                seed_load,
   input  logic [WIDTH-1:0]    seed_in,
   input  logic                sym_req,
   output logic                sym_valid,
   input  logic                sym_ready,
   output logic [SYM_BITS-1:0] sym,
   output logic                busy,
   output logic                lockup,
   input  logic                mark,
   input  logic                rewind
);

   localparam int                CW       = $clog2(SYM_BITS + 1);
   localparam logic [CW-1:0]     LAST     = CW'(SYM_BITS - 1);
   localparam logic [WIDTH-1:0]  TAP_MASK = TAPS[WIDTH-1:0];
   localparam logic [WIDTH-1:0]  SEED_W   = SEED[WIDTH-1:0];

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_VALID = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] w_q_shift;
   logic             w_fb;
   logic             w_zero_seed;
   logic             r_lockup;
   logic             w_lockup_nxt;
   logic             r_busy;
   logic             r_valid;

   assign w_fb        = ^(r_q & TAP_MASK);
   assign w_q_shift   = {r_q[WIDTH-2:0], w_fb};
   assign w_zero_seed = (seed_in == '0);

`ifdef LFSR_REPLAY_EN
   logic [WIDTH-1:0] r_snap;
   logic [WIDTH-1:0] w_snap_nxt;
`else
   logic w_unused_replay;
   assign w_unused_replay = mark | rewind;
`endif

   // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_q_nxt      = r_q;
      w_lockup_nxt = 1'b0;
`ifdef LFSR_REPLAY_EN
      w_snap_nxt   = r_snap;
`endif
      if (seed_load) begin
         w_lockup_nxt = w_zero_seed;
         w_q_nxt      = w_zero_seed ? SEED_W : seed_in;
         w_state_nxt  = S_IDLE;
         w_cnt_nxt    = '0;
      end
`ifdef LFSR_REPLAY_EN
      else if (r_state == S_IDLE && rewind) begin
         w_q_nxt = r_snap;
      end
      else if (r_state == S_IDLE && mark) begin
         w_snap_nxt = r_q;
      end
`endif
      else begin
         case (r_state)
            S_IDLE: begin
               if (sym_req) begin
                  w_state_nxt = S_SHIFT;
                  w_cnt_nxt   = '0;
               end
            end
            S_SHIFT: begin
               w_q_nxt = w_q_shift;
               if (r_cnt == LAST) begin
                  w_state_nxt = S_VALID;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            S_VALID: begin
               // q stays frozen here so the presented symbol cannot change under the consumer.
               if (sym_ready) begin
                  w_state_nxt = sym_req ? S_SHIFT : S_IDLE;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_q      <= SEED_W;
         r_lockup <= 1'b0;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_q      <= w_q_nxt;
         r_lockup <= w_lockup_nxt;
         r_busy   <= (w_state_nxt != S_IDLE);
         r_valid  <= (w_state_nxt == S_VALID);
      end
   end

`ifdef LFSR_REPLAY_EN
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_snap <= SEED_W;
      end else begin
         r_snap <= w_snap_nxt;
      end
   end
`endif

   assign sym_valid = r_valid;
   assign sym       = r_q[SYM_BITS-1:0];
   assign busy      = r_busy;
   assign lockup    = r_lockup;

endmodule

// File: tb/tb_lfsr_symbol_gen.sv
// Self-checking bench for lfsr_symbol_gen: scoreboard of model-predicted symbols, plus an 8-bit
// instance that walks the full 255-state period.
module tb_lfsr_symbol_gen;

   localparam int          W    = 64;
   localparam int          SB   = 2;
   localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
   localparam logic [63:0] SEED = 64'h3AFE_6029_F15A_5298;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          seed_load;
   logic [W-1:0]  seed_in;
   logic          sym_req;
   logic          sym_valid;
   logic          sym_ready;
   logic [SB-1:0] sym;
   logic          busy;
   logic          lockup;
   logic          mark;
   logic          rewind;

   logic          seed_load8;
   logic [7:0]    seed_in8;
   logic          sym_req8;
   logic          sym_valid8;
   logic          sym_ready8;
   logic [0:0]    sym8;
   logic          busy8;
   logic          lockup8;
   logic          mark8;
   logic          rewind8;

   int            checks   = 0;
   int            failures = 0;
   logic [SB-1:0] exp_q[$];
   logic [63:0]   m_q;
   logic [63:0]   m_snap;
   logic [7:0]    m8;

   always #5 clock = ~clock;

   lfsr_symbol_gen #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED), .SYM_BITS(SB)) dut (
      .clock(clock), .reset_n(reset_n), .seed_load(seed_load), .seed_in(seed_in),
      .sym_req(sym_req), .sym_valid(sym_valid), .sym_ready(sym_ready), .sym(sym),
      .busy(busy), .lockup(lockup), .mark(mark), .rewind(rewind)
   );

   lfsr_symbol_gen #(.WIDTH(8), .TAPS(64'h0000_0000_0000_00B8), .SEED(64'h0000_0000_0000_0001),
                     .SYM_BITS(1)) dut8 (
      .clock(clock), .reset_n(reset_n), .seed_load(seed_load8), .seed_in(seed_in8),
      .sym_req(sym_req8), .sym_valid(sym_valid8), .sym_ready(sym_ready8), .sym(sym8),
      .busy(busy8), .lockup(lockup8), .mark(mark8), .rewind(rewind8)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [63:0] model_shift(input logic [63:0] q);
      return {q[62:0], ^(q & TAPS)};
   endfunction

   task automatic push_expected();
      for (int i = 0; i < SB; i++) m_q = model_shift(m_q);
      exp_q.push_back(m_q[SB-1:0]);
   endtask

   task automatic pop_check(input string tag);
      logic [SB-1:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         check(tag, sym, e);
      end
   endtask

   // Bounded wait for sym_valid; 'start' is the number of edges already seen since sampling.
   task automatic wait_valid(input int start, output int edges);
      edges = start;
      while (!sym_valid && edges < 20) begin
         step();
         edges++;
      end
   endtask

   task automatic draw(input string tag, output logic [SB-1:0] s);
      int n;
      sym_req = 1'b1;
      step();
      sym_req = 1'b0;
      push_expected();
      wait_valid(1, n);
      check({tag, "_latency"}, n, SB + 1);
      s = sym;
      pop_check(tag);
      sym_ready = 1'b1;
      step();
      sym_ready = 1'b0;
      check({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [SB-1:0] s;
      logic [SB-1:0] held;
      logic [SB-1:0] seq_a[8];
      logic [63:0]   new_seed;
      int            n;
      int            zeros;
      int            early;

      reset_n = 1'b0; seed_load = 1'b0; seed_in = '0; sym_req = 1'b0; sym_ready = 1'b0;
      mark = 1'b0; rewind = 1'b0;
      seed_load8 = 1'b0; seed_in8 = '0; sym_req8 = 1'b0; sym_ready8 = 1'b0;
      mark8 = 1'b0; rewind8 = 1'b0;
      step();
      step();
      check("rst_valid", sym_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_lockup", lockup, 1'b0);
      check("rst_sym", sym, SEED[SB-1:0]);
      check("rst_q", dut.r_q, SEED);
      reset_n = 1'b1;
      m_q = SEED;

      // First two symbols after reset
      draw("sym1", s);
      check("sym1_const", s, 2'b00);
      draw("sym2", s);
      check("sym2_const", s, 2'b11);

      // Consumer stall: VALID holds for 10 cycles
      sym_req = 1'b1;
      step();
      sym_req = 1'b0;
      push_expected();
      wait_valid(1, n);
      check("hold_latency", n, SB + 1);
      held = sym;
      for (int i = 0; i < 10; i++) begin
         check("hold_valid", sym_valid, 1'b1);
         check("hold_sym", sym, held);
         check("hold_busy", busy, 1'b1);
         check("hold_q", dut.r_q, m_q);
         step();
      end
      pop_check("hold");
      sym_ready = 1'b1;
      step();
      sym_ready = 1'b0;
      check("hold_release_busy", busy, 1'b0);
      check("hold_release_valid", sym_valid, 1'b0);

      // Back-to-back symbols with req/ready held high
      sym_ready = 1'b1;
      sym_req   = 1'b1;
      step();
      push_expected();
      for (int k = 0; k < 3; k++) begin
         wait_valid(1, n);
         check("b2b_period", n, SB + 1);
         pop_check("b2b");
         if (k < 2) push_expected();
         else sym_req = 1'b0;
         step();
      end
      sym_ready = 1'b0;
      check("b2b_idle", busy, 1'b0);

      // Zero seed triggers lockup substitution
      seed_in   = '0;
      seed_load = 1'b1;
      step();
      seed_load = 1'b0;
      m_q = SEED;
      check("lockup_pulse", lockup, 1'b1);
      check("lockup_q", dut.r_q, SEED);
      check("lockup_busy", busy, 1'b0);
      step();
      check("lockup_one_cycle", lockup, 1'b0);
      draw("post_lockup", s);
      check("post_lockup_const", s, 2'b00);

      // Nonzero seed loads as given
      new_seed  = 64'h0123_4567_89AB_CDEF;
      seed_in   = new_seed;
      seed_load = 1'b1;
      step();
      seed_load = 1'b0;
      m_q = new_seed;
      check("seed_no_lockup", lockup, 1'b0);
      check("seed_q", dut.r_q, new_seed);
      draw("post_seed", s);

      // seed_load during SHIFT aborts the request
      sym_req = 1'b1;
      step();
      sym_req = 1'b0;
      check("abort_in_shift", busy, 1'b1);
      new_seed  = 64'hDEAD_BEEF_0000_0001;
      seed_in   = new_seed;
      seed_load = 1'b1;
      step();
      seed_load = 1'b0;
      m_q = new_seed;
      check("abort_busy", busy, 1'b0);
      check("abort_q", dut.r_q, new_seed);
      for (int i = 0; i < 6; i++) begin
         check("abort_no_valid", sym_valid, 1'b0);
         step();
      end
      draw("after_abort", s);

      // rewind during SHIFT is ignored
      sym_req = 1'b1;
      step();
      sym_req = 1'b0;
      push_expected();
      rewind = 1'b1;
      step();
      rewind = 1'b0;
      wait_valid(2, n);
      check("rewind_shift_latency", n, SB + 1);
      pop_check("rewind_in_shift");
      sym_ready = 1'b1;
      step();
      sym_ready = 1'b0;

`ifdef LFSR_REPLAY_EN
      mark = 1'b1;
      step();
      mark = 1'b0;
      m_snap = m_q;
      check("mark_busy", busy, 1'b0);
      for (int i = 0; i < 8; i++) begin
         draw("replay_a", s);
         seq_a[i] = s;
      end
      rewind = 1'b1;
      step();
      rewind = 1'b0;
      m_q = m_snap;
      check("rewind_q", dut.r_q, m_snap);
      for (int i = 0; i < 8; i++) begin
         draw("replay_b", s);
         check("replay_match", s, seq_a[i]);
      end
      // mark+rewind together: rewind wins and the request is dropped
      mark = 1'b1; rewind = 1'b1; sym_req = 1'b1;
      step();
      mark = 1'b0; rewind = 1'b0; sym_req = 1'b0;
      m_q = m_snap;
      check("mark_rewind_busy", busy, 1'b0);
      check("mark_rewind_q", dut.r_q, m_snap);
      draw("after_replay", s);
`else
      mark = 1'b1; rewind = 1'b1;
      step();
      mark = 1'b0; rewind = 1'b0;
      check("noreplay_busy", busy, 1'b0);
      check("noreplay_q", dut.r_q, m_q);
      for (int i = 0; i < 8; i++) seq_a[i] = '0;
      // mark does not drop a request when replay is not built
      mark = 1'b1; sym_req = 1'b1;
      step();
      mark = 1'b0; sym_req = 1'b0;
      push_expected();
      check("noreplay_req_taken", busy, 1'b1);
      wait_valid(1, n);
      check("noreplay_latency", n, SB + 1);
      pop_check("noreplay_sym");
      sym_ready = 1'b1;
      step();
      sym_ready = 1'b0;
`endif

      // Reset in the middle of SHIFT
      sym_req = 1'b1;
      step();
      sym_req = 1'b0;
      step();
      reset_n = 1'b0;
      step();
      check("midrst_busy", busy, 1'b0);
      check("midrst_valid", sym_valid, 1'b0);
      check("midrst_lockup", lockup, 1'b0);
      check("midrst_sym", sym, SEED[SB-1:0]);
      check("midrst_q", dut.r_q, SEED);
      reset_n = 1'b1;
      m_q = SEED;
      exp_q.delete();
      draw("post_midrst", s);
      check("post_midrst_const", s, 2'b00);

      // 8-bit instance: full maximal-length period from seed 8'h01
      m8    = 8'h01;
      zeros = 0;
      early = 0;
      sym_req8   = 1'b1;
      sym_ready8 = 1'b1;
      for (int i = 0; i < 255; i++) begin
         n = 0;
         while (!sym_valid8 && n < 10) begin
            step();
            n++;
         end
         if (!sym_valid8) begin
            check("w8_valid_timeout", sym_valid8, 1'b1);
            break;
         end
         m8 = {m8[6:0], ^(m8 & 8'hB8)};
         check("w8_sym", sym8, m8[0]);
         if (dut8.r_q == 8'h00) zeros++;
         if (i < 254 && dut8.r_q == 8'h01) early++;
         if (i == 254) check("w8_period_return", dut8.r_q, 8'h01);
         step();
      end
      sym_req8   = 1'b0;
      sym_ready8 = 1'b0;
      check("w8_never_zero", zeros, 0);
      check("w8_no_early_return", early, 0);
      check("w8_no_lockup", lockup8, 1'b0);
      check("w8_busy", busy8, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
